// File: rtl/uart_rx_core_if.sv
// Receive-side signal bundle for uart_rx_core: serial line, acknowledge, and the
// received word with its status flags.
interface uart_rx_core_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rxd;
  logic                 d_ack;
  logic [DATA_BITS-1:0] dout;
  logic                 d_rdy;
  logic                 rx_rdy;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  // Receiver side.
  modport master (
    input  rxd, d_ack,
    output dout, d_rdy, rx_rdy, frame_err, parity_err, overrun
  );

  // Line driver and consumer side.
  modport slave (
    output rxd, d_ack,
    input  dout, d_rdy, rx_rdy, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with configurable data bits, parity and stop bits.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx_core #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic            clk,
  input logic            rst,
  uart_rx_core_if.master bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam int unsigned SW   = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned SampleOfs = 1;
`else
  localparam int unsigned SampleOfs = 0;
`endif
  // Only the start-bit decision moves; later points stay one full bit apart.
  localparam logic [SW-1:0] StartPoint = SW'(Half - 1 + SampleOfs);
  localparam logic [SW-1:0] BitPoint   = SW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LastData   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LastStop   = 4'(STOP_BITS - 1);
  localparam logic          OddPar     = (PARITY == 1);

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [SW-1:0]        sctr_q, sctr_d;
  logic [3:0]           bctr_q, bctr_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 d_rdy_q, d_rdy_d, frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d, overrun_q, overrun_d;
  logic                 rxs, smp_bit, tick, stop_err, commit;

  assign sync_d = {sync_q[0], bus.rxd};
  assign rxs    = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic rxs_h1_q, rxs_h2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxs_h1_q <= 1'b1;
      rxs_h2_q <= 1'b1;
    end else begin
      rxs_h1_q <= rxs;
      rxs_h2_q <= rxs_h1_q;
    end
  end

  assign smp_bit = (rxs & rxs_h1_q) | (rxs & rxs_h2_q) | (rxs_h1_q & rxs_h2_q);
`else
  assign smp_bit = rxs;
`endif

  assign tick     = (state_q == StStart) ? (sctr_q == StartPoint) : (sctr_q == BitPoint);
  assign stop_err = ferr_q | ~smp_bit;
  assign commit   = (state_q == StStop) && tick && (bctr_q == LastStop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!rxs) state_d = StStart;
      StStart:  if (tick) state_d = smp_bit ? StIdle : StData;
      StData:   if (tick && bctr_q == LastData) state_d = (PARITY != 0) ? StParity : StStop;
      StParity: if (tick) state_d = StStop;
      StStop:   if (tick && bctr_q == LastStop) state_d = stop_err ? StBreak : StIdle;
      StBreak:  if (rxs) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.rx_rdy     = (state_q == StIdle);
    bus.dout       = dout_q;
    bus.d_rdy      = d_rdy_q;
    bus.frame_err  = frame_err_q;
    bus.parity_err = parity_err_q;
    bus.overrun    = overrun_q;
  end

  always_comb begin
    sctr_d       = sctr_q + SW'(1);
    bctr_d       = bctr_q;
    shreg_d      = shreg_q;
    ferr_d       = ferr_q;
    perr_d       = perr_q;
    dout_d       = dout_q;
    d_rdy_d      = d_rdy_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;

    if (state_d != state_q) begin
      sctr_d = '0;
      bctr_d = '0;
    end else if (state_q == StIdle || state_q == StBreak) begin
      sctr_d = '0;
    end else if (tick) begin
      sctr_d = '0;
      bctr_d = bctr_q + 4'd1;
    end

    if (state_q == StIdle) begin
      ferr_d = 1'b0;
      perr_d = 1'b0;
    end
    if (state_q == StData && tick) shreg_d = {smp_bit, shreg_q[DATA_BITS-1:1]};
    if (state_q == StParity && tick) perr_d = (^shreg_q) ^ smp_bit ^ OddPar;
    if (state_q == StStop && tick) ferr_d = stop_err;

    if (commit) begin
      if (!d_rdy_q || bus.d_ack) begin
        dout_d       = shreg_q;
        frame_err_d  = stop_err;
        parity_err_d = perr_q;
        d_rdy_d      = 1'b1;
        overrun_d    = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus.d_ack && d_rdy_q) begin
      d_rdy_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 2'b11;
      sctr_q       <= '0;
      bctr_q       <= '0;
      shreg_q      <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      dout_q       <= '0;
      d_rdy_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      sctr_q       <= sctr_d;
      bctr_q       <= bctr_d;
      shreg_q      <= shreg_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      dout_q       <= dout_d;
      d_rdy_q      <= d_rdy_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule
